// File: rtl/medidor_nota_tempo_if.sv
// Bus between the game datapath and the key-press meter.
// The game side arms a measurement and reads back the results.
`timescale 1ns/1ps
interface medidor_nota_tempo_if #(
    parameter int N_BOTOES = 13,
    parameter int TEMPO_W  = 4
);
    logic                iniciar;
    logic [4:0]          nota_esperada;
    logic [TEMPO_W-1:0]  tempo_esperado;
    logic [N_BOTOES-1:0] botoes;
    logic                ocupado;
    logic                pronto;
    logic                nota_correta;
    logic                tempo_correto;
    logic [4:0]          nota_medida;
    logic [TEMPO_W-1:0]  tempo_medido;
    logic                multiplos;
    logic                timeout;

    modport master (
        output iniciar, nota_esperada, tempo_esperado, botoes,
        input  ocupado, pronto, nota_correta, tempo_correto,
               nota_medida, tempo_medido, multiplos, timeout
    );

    modport slave (
        input  iniciar, nota_esperada, tempo_esperado, botoes,
        output ocupado, pronto, nota_correta, tempo_correto,
               nota_medida, tempo_medido, multiplos, timeout
    );
endinterface

// File: rtl/medidor_nota_tempo.sv
// Measures one key press (which key, how long it was held) and grades it
// against the expected note and tempo latched when the measurement is armed.
`timescale 1ns/1ps
module medidor_nota_tempo #(
    parameter int CLOCK_FREQ     = 5000,
    parameter int N_BOTOES       = 13,
    parameter int TEMPO_W        = 4,
    parameter int UNIDADE        = CLOCK_FREQ / 2,
    parameter int TOLERANCIA     = CLOCK_FREQ / 8,
    parameter int TIMEOUT_CICLOS = 5 * CLOCK_FREQ
) (
    input  logic                clock,
    input  logic                reset,
    medidor_nota_tempo_if.slave bus
);
    localparam int CICLOS_MAX = (2 ** TEMPO_W) * UNIDADE;
    localparam int CW         = $clog2(CICLOS_MAX + 1);
    localparam int WW         = $clog2(TIMEOUT_CICLOS + 1);
    localparam int SW         = $clog2(UNIDADE + 1);

    localparam logic [CW-1:0]      CICLOS_SAT = CW'(CICLOS_MAX);
    localparam logic [CW-1:0]      UNID_C     = CW'(UNIDADE);
    localparam logic [CW-1:0]      TOL_C      = CW'(TOLERANCIA);
    localparam logic [WW-1:0]      TIMEOUT_C  = WW'(TIMEOUT_CICLOS - 1);
    localparam logic [SW-1:0]      SUB_ULT    = SW'(UNIDADE - 1);
    localparam logic [TEMPO_W-1:0] TEMPO_SAT  = '1;
    // The first counted cycle plus the half-unit rounding offset may already fill a unit.
    localparam bit                 SUB_CHEIO  = (UNIDADE / 2 + 1) >= UNIDADE;
    localparam logic [SW-1:0]      SUB_INI    = SUB_CHEIO ? '0 : SW'(UNIDADE / 2 + 1);
    localparam logic [TEMPO_W-1:0] UNID_INI   = SUB_CHEIO ? TEMPO_W'(1) : '0;

    typedef enum logic [2:0] {OCIOSO, ESPERA, PRESSIONADO, AVALIA, FIM} estado_t;

    estado_t             estado_q;
    logic [N_BOTOES-1:0] sync1_q, sync2_q, vetor_q;
    logic [4:0]          nota_esp_q;
    logic [TEMPO_W-1:0]  tempo_esp_q;
    logic [WW-1:0]       espera_q;
    logic [CW-1:0]       ciclos_q;
    logic [SW-1:0]       sub_q;
    logic [TEMPO_W-1:0]  unid_q;
    logic                varios_q;
    logic                ocupado_q, pronto_q, nota_correta_q, tempo_correto_q;
    logic                multiplos_q, timeout_q;
    logic [4:0]          nota_medida_q;
    logic [TEMPO_W-1:0]  tempo_medido_q;

    logic [N_BOTOES-1:0] botoes_s;
    logic                varios_s_d;
    logic [4:0]          nota_cod_d, nota_d;
    logic                nota_ok_d, tempo_ok_d;
    logic [CW-1:0]       produto_d, dif_d;

    assign botoes_s   = sync2_q;
    assign varios_s_d = |(botoes_s & (botoes_s - N_BOTOES'(1)));

    always_comb begin
        nota_cod_d = '0;
        for (int i = 0; i < N_BOTOES; i++) begin
            if (vetor_q[i]) nota_cod_d = 5'(i + 1);
        end
    end

    assign nota_d     = varios_q ? 5'h1F : nota_cod_d;
    assign nota_ok_d  = !varios_q && (nota_esp_q != 5'd0) && (nota_esp_q <= 5'(N_BOTOES))
                        && (nota_cod_d == nota_esp_q);
    assign produto_d  = CW'(tempo_esp_q) * UNID_C;
    assign dif_d      = (ciclos_q >= produto_d) ? (ciclos_q - produto_d) : (produto_d - ciclos_q);
    assign tempo_ok_d = (dif_d <= TOL_C);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q        <= OCIOSO;
            sync1_q         <= '0;
            sync2_q         <= '0;
            vetor_q         <= '0;
            nota_esp_q      <= '0;
            tempo_esp_q     <= '0;
            espera_q        <= '0;
            ciclos_q        <= '0;
            sub_q           <= '0;
            unid_q          <= '0;
            varios_q        <= 1'b0;
            ocupado_q       <= 1'b0;
            pronto_q        <= 1'b0;
            nota_correta_q  <= 1'b0;
            tempo_correto_q <= 1'b0;
            multiplos_q     <= 1'b0;
            timeout_q       <= 1'b0;
            nota_medida_q   <= '0;
            tempo_medido_q  <= '0;
        end else begin
            sync1_q  <= bus.botoes;
            sync2_q  <= sync1_q;
            pronto_q <= 1'b0;
            unique case (estado_q)
                OCIOSO: begin
                    if (bus.iniciar) begin
                        nota_esp_q      <= bus.nota_esperada;
                        tempo_esp_q     <= bus.tempo_esperado;
                        espera_q        <= '0;
                        varios_q        <= 1'b0;
                        ocupado_q       <= 1'b1;
                        nota_correta_q  <= 1'b0;
                        tempo_correto_q <= 1'b0;
                        multiplos_q     <= 1'b0;
                        timeout_q       <= 1'b0;
                        nota_medida_q   <= '0;
                        tempo_medido_q  <= '0;
                        estado_q        <= ESPERA;
                    end
                end
                ESPERA: begin
                    if (botoes_s != '0) begin
                        vetor_q  <= botoes_s;
                        varios_q <= varios_s_d;
                        ciclos_q <= CW'(1);
                        sub_q    <= SUB_INI;
                        unid_q   <= UNID_INI;
                        estado_q <= PRESSIONADO;
                    end else if (espera_q == TIMEOUT_C) begin
                        timeout_q <= 1'b1;
                        pronto_q  <= 1'b1;
                        ocupado_q <= 1'b0;
                        estado_q  <= FIM;
                    end else begin
                        espera_q <= espera_q + WW'(1);
                    end
                end
                PRESSIONADO: begin
                    if (varios_s_d) varios_q <= 1'b1;
                    // Release and any change of the key set both end the press.
                    if (botoes_s != vetor_q) begin
                        estado_q <= AVALIA;
                    end else if (ciclos_q != CICLOS_SAT) begin
                        ciclos_q <= ciclos_q + CW'(1);
                        if (sub_q == SUB_ULT) begin
                            sub_q <= '0;
                            if (unid_q != TEMPO_SAT) unid_q <= unid_q + TEMPO_W'(1);
                        end else begin
                            sub_q <= sub_q + SW'(1);
                        end
                    end
                end
                AVALIA: begin
                    nota_medida_q   <= nota_d;
                    nota_correta_q  <= nota_ok_d;
                    tempo_medido_q  <= unid_q;
                    tempo_correto_q <= tempo_ok_d;
                    multiplos_q     <= varios_q;
                    pronto_q        <= 1'b1;
                    ocupado_q       <= 1'b0;
                    estado_q        <= FIM;
                end
                FIM: estado_q <= OCIOSO;
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign bus.ocupado       = ocupado_q;
    assign bus.pronto        = pronto_q;
    assign bus.nota_correta  = nota_correta_q;
    assign bus.tempo_correto = tempo_correto_q;
    assign bus.nota_medida   = nota_medida_q;
    assign bus.tempo_medido  = tempo_medido_q;
    assign bus.multiplos     = multiplos_q;
    assign bus.timeout       = timeout_q;
endmodule

// File: tb/tb_medidor_nota_tempo.sv
// Directed bench for medidor_nota_tempo at CLOCK_FREQ=5000
// (unit 2500 cycles, tolerance 625 cycles, timeout 25000 cycles).
`timescale 1ns/1ps
module tb_medidor_nota_tempo;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    medidor_nota_tempo_if #(.N_BOTOES(13), .TEMPO_W(4)) bus ();

    medidor_nota_tempo #(.CLOCK_FREQ(5000), .N_BOTOES(13), .TEMPO_W(4)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [4:0] nota, input logic [3:0] tempo);
        bus.nota_esperada  = nota;
        bus.tempo_esperado = tempo;
        bus.iniciar        = 1'b1;
        tick(1);
        bus.iniciar        = 1'b0;
    endtask

    task automatic hold(input logic [12:0] vec, input int n);
        bus.botoes = vec;
        tick(n);
        bus.botoes = '0;
    endtask

    // Release edge + 2 sync + PRESSIONADO->AVALIA + AVALIA->FIM: pronto after the 4th edge.
    task automatic latency(input string tag);
        tick(3);
        check({tag, "_pronto_cedo"}, bus.pronto, 1'b0);
        tick(1);
        check({tag, "_pronto"}, bus.pronto, 1'b1);
        check({tag, "_ocupado"}, bus.ocupado, 1'b0);
    endtask

    initial begin
        int  k;
        bit  visto;
        tests              = 0;
        fails              = 0;
        rst_n              = 1'b0;
        bus.iniciar        = 1'b0;
        bus.nota_esperada  = '0;
        bus.tempo_esperado = '0;
        bus.botoes         = '0;

        tick(3);
        check("rst_pronto", bus.pronto, 1'b0);
        check("rst_ocupado", bus.ocupado, 1'b0);
        check("rst_nota_medida", bus.nota_medida, 5'd0);
        check("rst_timeout", bus.timeout, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // 1: key 3 held exactly 3 units
        arm(5'd3, 4'd3);
        check("t1_ocupado", bus.ocupado, 1'b1);
        hold(13'h0004, 7500);
        latency("t1");
        check("t1_nota_correta", bus.nota_correta, 1'b1);
        check("t1_tempo_correto", bus.tempo_correto, 1'b1);
        check("t1_nota_medida", bus.nota_medida, 5'd3);
        check("t1_tempo_medido", bus.tempo_medido, 4'd3);
        check("t1_multiplos", bus.multiplos, 1'b0);
        check("t1_timeout", bus.timeout, 1'b0);
        tick(1);
        check("t1_pronto_pulso", bus.pronto, 1'b0);
        check("t1_resultado_mantido", bus.nota_medida, 5'd3);
        tick(3);

        // 2a: 10700 cycles is 700 off 4 units, rounds to 4
        arm(5'd5, 4'd4);
        hold(13'h0010, 10700);
        latency("t2a");
        check("t2a_nota_correta", bus.nota_correta, 1'b1);
        check("t2a_tempo_correto", bus.tempo_correto, 1'b0);
        check("t2a_tempo_medido", bus.tempo_medido, 4'd4);
        tick(3);

        // 2b: difference exactly at the tolerance
        arm(5'd5, 4'd4);
        hold(13'h0010, 10625);
        latency("t2b");
        check("t2b_tempo_correto", bus.tempo_correto, 1'b1);
        check("t2b_tempo_medido", bus.tempo_medido, 4'd4);
        tick(3);

        // 3: wrong key, right duration
        arm(5'd5, 4'd1);
        hold(13'h0008, 2500);
        latency("t3");
        check("t3_nota_correta", bus.nota_correta, 1'b0);
        check("t3_nota_medida", bus.nota_medida, 5'd4);
        check("t3_tempo_correto", bus.tempo_correto, 1'b1);
        check("t3_tempo_medido", bus.tempo_medido, 4'd1);
        tick(3);

        // 4: second key joins mid-press
        arm(5'd1, 4'd1);
        bus.botoes = 13'h0001;
        tick(100);
        bus.botoes = 13'h0041;
        k = 0;
        while (bus.pronto !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        check("t4_pronto", bus.pronto, 1'b1);
        check("t4_multiplos", bus.multiplos, 1'b1);
        check("t4_nota_medida", bus.nota_medida, 5'h1F);
        check("t4_nota_correta", bus.nota_correta, 1'b0);
        bus.botoes = '0;
        tick(5);

        // 5: no press at all
        arm(5'd2, 4'd2);
        k = 0;
        while (bus.pronto !== 1'b1 && k < 30000) begin
            tick(1);
            k++;
        end
        check("t5_pronto", bus.pronto, 1'b1);
        check("t5_espera", k, 25000);
        check("t5_timeout", bus.timeout, 1'b1);
        check("t5_ocupado", bus.ocupado, 1'b0);
        check("t5_nota_medida", bus.nota_medida, 5'd0);
        check("t5_tempo_medido", bus.tempo_medido, 4'd0);
        check("t5_nota_correta", bus.nota_correta, 1'b0);
        tick(3);

        // 6: reset in the middle of a press
        arm(5'd3, 4'd3);
        bus.botoes = 13'h0004;
        tick(3000);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ocupado", bus.ocupado, 1'b0);
        check("t6_rst_pronto", bus.pronto, 1'b0);
        check("t6_rst_timeout", bus.timeout, 1'b0);
        tick(2);
        rst_n = 1'b1;
        visto = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick(1);
            if (bus.pronto === 1'b1) visto = 1'b1;
        end
        bus.botoes = '0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.pronto === 1'b1) visto = 1'b1;
        end
        check("t6_sem_pronto", visto, 1'b0);
        check("t6_ocupado", bus.ocupado, 1'b0);

        // a press without iniciar is ignored
        visto = 1'b0;
        bus.botoes = 13'h0001;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (bus.pronto === 1'b1 || bus.ocupado === 1'b1) visto = 1'b1;
        end
        bus.botoes = '0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.pronto === 1'b1 || bus.ocupado === 1'b1) visto = 1'b1;
        end
        check("t6_sem_iniciar", visto, 1'b0);
        check("t6_nota_medida", bus.nota_medida, 5'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
